// File: rtl/message_formatter.sv
// rtl/message_formatter.sv - paced ASCII hex line formatter for a multi-word vector
// Optional build macro: MESSAGE_FORMATTER_LOWERCASE_EN selects lowercase hex letters a-f.
module message_formatter #(
  parameter int WIDTH       = 32,
  parameter int COUNT       = 2,
  parameter int TX_INTERVAL = 4
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   I_STB,
  input  logic [WIDTH*COUNT-1:0] I_DAT,
  output logic                   O_STB,
  output logic [7:0]             O_DAT
);

  localparam int NIBS   = WIDTH / 4;
  localparam int NIB_W  = (NIBS > 1) ? $clog2(NIBS) : 1;
  localparam int WRD_W  = (COUNT > 1) ? $clog2(COUNT) : 1;
  localparam int TICK_W = (TX_INTERVAL > 1) ? $clog2(TX_INTERVAL) : 1;
  localparam logic [NIB_W-1:0]  NIB_TOP  = NIB_W'(NIBS - 1);
  localparam logic [WRD_W-1:0]  WRD_TOP  = WRD_W'(COUNT - 1);
  localparam logic [TICK_W-1:0] TICK_TOP = TICK_W'(TX_INTERVAL - 1);

  typedef enum logic [2:0] {IDLE, SEND_DIGIT, SEND_SEP, SEND_CR, SEND_LF} state_t;

  state_t                 state, state_nxt, cur;
  logic [NIB_W-1:0]       nib, nib_nxt, nib_eff;
  logic [WRD_W-1:0]       wrd, wrd_nxt, wrd_eff;
  logic [TICK_W-1:0]      tick, tick_nxt;
  logic [WIDTH*COUNT-1:0] shadow, shadow_nxt, src;
  logic [3:0]             nibble;
  logic                   emit;
  logic [7:0]             char;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state  <= IDLE;
      nib    <= '0;
      wrd    <= '0;
      tick   <= '0;
      shadow <= '0;
      O_STB  <= 1'b0;
      O_DAT  <= 8'h00;
    end else begin
      state  <= state_nxt;
      nib    <= nib_nxt;
      wrd    <= wrd_nxt;
      tick   <= tick_nxt;
      shadow <= shadow_nxt;
      O_STB  <= emit;
      if (emit) O_DAT <= char;
    end
  end

  // The capture edge emits the first digit straight from I_DAT, so IDLE acts as SEND_DIGIT at the top position.
  always_comb begin
    state_nxt  = state;
    nib_nxt    = nib;
    wrd_nxt    = wrd;
    shadow_nxt = shadow;
    tick_nxt   = (state == IDLE || tick == '0) ? tick : tick - 1'b1;
    if (state == IDLE && emit) shadow_nxt = I_DAT;
    if (emit) begin
      tick_nxt = TICK_TOP;
      case (cur)
        SEND_DIGIT: begin
          wrd_nxt = wrd_eff;
          if (nib_eff != '0) begin
            nib_nxt   = nib_eff - 1'b1;
            state_nxt = SEND_DIGIT;
          end else if (wrd_eff != '0) begin
            state_nxt = SEND_SEP;
          end else begin
            state_nxt = SEND_CR;
          end
        end
        SEND_SEP: begin
          state_nxt = SEND_DIGIT;
          nib_nxt   = NIB_TOP;
          wrd_nxt   = wrd - 1'b1;
        end
        SEND_CR: state_nxt = SEND_LF;
        SEND_LF: begin
          state_nxt = IDLE;
          nib_nxt   = '0;
          wrd_nxt   = '0;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // A strobe coinciding with the LF pulse (O_STB still high in IDLE) is dropped.
  always_comb begin
    cur     = (state == IDLE) ? SEND_DIGIT : state;
    nib_eff = (state == IDLE) ? NIB_TOP : nib;
    wrd_eff = (state == IDLE) ? WRD_TOP : wrd;
    emit    = (state == IDLE) ? (I_STB && !O_STB) : (tick == '0);
    src     = (state == IDLE) ? I_DAT : shadow;
    nibble  = 4'(src >> (32'(wrd_eff) * WIDTH + 32'(nib_eff) * 4));
    case (cur)
      SEND_SEP: char = 8'h5F;
      SEND_CR:  char = 8'h0D;
      SEND_LF:  char = 8'h0A;
      default: begin
        if (nibble < 4'd10) begin
          char = {4'h3, nibble};
        end else begin
`ifdef MESSAGE_FORMATTER_LOWERCASE_EN
          char = 8'h57 + {4'h0, nibble};
`else
          char = 8'h37 + {4'h0, nibble};
`endif
        end
      end
    endcase
  end

endmodule

// File: tb/tb_message_formatter.sv
// tb/tb_message_formatter.sv - directed self-checking bench for message_formatter
module tb_message_formatter;

  logic CLK = 1'b0;
  logic RST = 1'b0;
  always #5 CLK = ~CLK;

  logic        stb0 = 1'b0, stb1 = 1'b0, stb3 = 1'b0;
  logic [63:0] dat0 = '0, dat1 = '0;
  logic [23:0] dat3 = '0;
  logic        os0, os1, os3;
  logic [7:0]  od0, od1, od3;
  int          sel = 0;
  logic        o_stb_m;
  logic [7:0]  o_dat_m;
  int          total = 0;
  int          bad = 0;

`ifdef MESSAGE_FORMATTER_LOWERCASE_EN
  string s_a = "01234567_abcd4321\015\012";
  string s_b = "00000000_ffffffff\015\012";
  string s_c = "0a_b0_5c\015\012";
`else
  string s_a = "01234567_ABCD4321\015\012";
  string s_b = "00000000_FFFFFFFF\015\012";
  string s_c = "0A_B0_5C\015\012";
`endif

  message_formatter dut0 (
    .CLK(CLK), .RST(RST), .I_STB(stb0), .I_DAT(dat0), .O_STB(os0), .O_DAT(od0)
  );
  message_formatter #(.WIDTH(32), .COUNT(2), .TX_INTERVAL(1)) dut1 (
    .CLK(CLK), .RST(RST), .I_STB(stb1), .I_DAT(dat1), .O_STB(os1), .O_DAT(od1)
  );
  message_formatter #(.WIDTH(8), .COUNT(3), .TX_INTERVAL(4)) dut3 (
    .CLK(CLK), .RST(RST), .I_STB(stb3), .I_DAT(dat3), .O_STB(os3), .O_DAT(od3)
  );

  always_comb begin
    case (sel)
      1:       begin o_stb_m = os1; o_dat_m = od1; end
      3:       begin o_stb_m = os3; o_dat_m = od3; end
      default: begin o_stb_m = os0; o_dat_m = od0; end
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pulse(input int s, input logic [63:0] d);
    @(negedge CLK);
    case (s)
      1:       begin stb1 = 1'b1; dat1 = d; end
      3:       begin stb3 = 1'b1; dat3 = d[23:0]; end
      default: begin stb0 = 1'b1; dat0 = d; end
    endcase
    sel = s;
    @(negedge CLK);
    stb0 = 1'b0; stb1 = 1'b0; stb3 = 1'b0;
    dat0 = ~dat0; dat1 = ~dat1; dat3 = ~dat3;
  endtask

  task automatic expect_msg(input string exp, input int gap, input int n);
    int waited;
    chk("first_stb", 32'(o_stb_m), 32'd1);
    chk("char0", 32'(o_dat_m), 32'(exp[0]));
    for (int i = 1; i < n; i++) begin
      waited = 0;
      do begin
        @(negedge CLK);
        waited++;
      end while (o_stb_m !== 1'b1 && waited < gap + 4);
      chk($sformatf("gap%0d", i), 32'(waited), 32'(gap));
      chk($sformatf("char%0d", i), 32'(o_dat_m), 32'(exp[i]));
    end
  endtask

  task automatic expect_quiet(input string tag, input int cycles);
    int pulses = 0;
    repeat (cycles) begin
      @(negedge CLK);
      if (o_stb_m !== 1'b0) pulses++;
    end
    chk(tag, 32'(pulses), 32'd0);
  endtask

  initial begin
    #2;
    chk("rst_stb0", 32'(os0), 32'd0);
    chk("rst_dat0", 32'(od0), 32'h00);
    chk("rst_stb1", 32'(os1), 32'd0);
    chk("rst_dat3", 32'(od3), 32'h00);
    repeat (2) @(negedge CLK);
    RST = 1'b1;

    pulse(0, 64'h01234567_ABCD4321);
    expect_msg(s_a, 4, 19);
    expect_quiet("quiet_a", 12);

    pulse(0, 64'h01234567_ABCD4321);
    fork
      begin
        repeat (9) @(negedge CLK);
        stb0 = 1'b1;
        @(negedge CLK);
        stb0 = 1'b0;
      end
    join_none
    expect_msg(s_a, 4, 19);
    expect_quiet("quiet_second_stb", 12);

    pulse(1, 64'h00000000_FFFFFFFF);
    expect_msg(s_b, 1, 19);
    stb1 = 1'b1;
    @(negedge CLK);
    stb1 = 1'b0;
    chk("lf_cycle_stb_dropped", 32'(os1), 32'd0);
    expect_quiet("quiet_b", 6);

    pulse(3, 64'h0000000000_0AB05C);
    expect_msg(s_c, 4, 10);
    expect_quiet("quiet_c", 8);

    pulse(0, 64'h01234567_ABCD4321);
    expect_msg(s_a, 4, 5);
    @(posedge CLK);
    #2 RST = 1'b0;
    #1;
    chk("mid_rst_stb", 32'(os0), 32'd0);
    chk("mid_rst_dat", 32'(od0), 32'h00);
    repeat (2) @(negedge CLK);
    RST = 1'b1;
    expect_quiet("quiet_after_rst", 25);
    pulse(0, 64'h01234567_ABCD4321);
    expect_msg(s_a, 4, 19);
    expect_quiet("quiet_end", 8);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
